// File: rtl/hft_fixed_pkg.sv
// Shared q32.32 fixed-point type and constants for the quoting datapath.
package hft_fixed_pkg;

  typedef logic signed [63:0] q32_32_t;

  localparam q32_32_t Q_ONE     = 64'sh0000_0001_0000_0000;
  localparam q32_32_t Q_NEG_ONE = 64'shFFFF_FFFF_0000_0000;
  localparam q32_32_t Q_MAX     = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam q32_32_t Q_MIN     = 64'sh8000_0000_0000_0000;

endpackage

// File: rtl/q32_mul_sat.sv
// Combinational signed q32.32 multiply with saturation to 64 bits; an optional
// negation is applied to the full product so that -(MIN * x) stays exact.
module q32_mul_sat
  import hft_fixed_pkg::*;
(
  input  q32_32_t a,
  input  q32_32_t b,
  input  logic    negate,
  output q32_32_t y
);

  logic signed [127:0] a_ext;
  logic signed [127:0] b_ext;
  logic signed [127:0] prod;
  logic signed [127:0] prod_sgn;
  logic signed [127:0] shifted;
  logic                overflow;

  assign a_ext    = a;
  assign b_ext    = b;
  assign prod     = a_ext * b_ext;
  assign prod_sgn = negate ? -prod : prod;
  assign shifted  = prod_sgn >>> 32;

  // Result fits when everything above bit 63 of the shifted product is sign.
  assign overflow = !((&shifted[127:63]) || (~|shifted[127:63]));

  always_comb begin
    y = shifted[63:0];
    if (overflow) begin
      y = shifted[127] ? Q_MIN : Q_MAX;
    end
  end

endmodule

// File: rtl/order_intensity_calc.sv
// Three-stage pipeline computing lambda = A * exp(-k * delta) around an
// external combinational exp_lut: S1 forms/clamps the argument, S2 captures
// the LUT value, S3 scales by the A snapshot taken at accept time.
module order_intensity_calc
  import hft_fixed_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [63:0]      i_delta,
  input  logic             i_cfg_we,
  input  logic [63:0]      i_k,
  input  logic [63:0]      i_a,
  output logic [63:0]      o_exp_arg,
  input  logic [63:0]      i_exp_value,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [63:0]      o_lambda,
  output logic             o_clamped,
  output logic [CNT_W-1:0] o_clamp_cnt
);

  // Handshake: a sample transfers in when i_valid && o_ready at a clock edge,
  // a result transfers out when o_valid && i_ready; the whole pipe freezes
  // only while a result is presented and not taken.
  logic en;
  assign en      = !(o_valid && !i_ready);
  assign o_ready = en;

  q32_32_t k_r;
  q32_32_t a_r;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      k_r <= '0;
      a_r <= Q_ONE;
    end else if (i_cfg_we) begin
      k_r <= i_k;
      a_r <= i_a;
    end
  end

  q32_32_t arg_raw;
  q32_32_t arg_clamped;
  logic    arg_clip;

  q32_mul_sat u_arg_mul (
    .a      (k_r),
    .b      (i_delta),
    .negate (1'b1),
    .y      (arg_raw)
  );

  always_comb begin
    arg_clamped = arg_raw;
    arg_clip    = 1'b0;
    if (arg_raw > Q_ONE) begin
      arg_clamped = Q_ONE;
      arg_clip    = 1'b1;
    end else if (arg_raw < Q_NEG_ONE) begin
      arg_clamped = Q_NEG_ONE;
      arg_clip    = 1'b1;
    end
  end

  logic    s1_valid;
  logic    s1_clip;
  q32_32_t s1_arg;
  q32_32_t s1_a;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_clip  <= 1'b0;
      s1_arg   <= '0;
      s1_a     <= '0;
    end else if (en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_clip <= arg_clip;
        s1_arg  <= arg_clamped;
        s1_a    <= a_r;
      end
    end
  end

  assign o_exp_arg = s1_arg;

  logic    s2_valid;
  logic    s2_clip;
  q32_32_t s2_exp;
  q32_32_t s2_a;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_valid <= 1'b0;
      s2_clip  <= 1'b0;
      s2_exp   <= '0;
      s2_a     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_clip  <= s1_clip;
      s2_exp   <= i_exp_value;
      s2_a     <= s1_a;
    end
  end

  q32_32_t lambda_next;

  q32_mul_sat u_lambda_mul (
    .a      (s2_a),
    .b      (s2_exp),
    .negate (1'b0),
    .y      (lambda_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_lambda  <= '0;
      o_clamped <= 1'b0;
    end else if (en) begin
      o_valid   <= s2_valid;
      o_lambda  <= lambda_next;
      o_clamped <= s2_valid && s2_clip;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_clamp_cnt <= '0;
    end else if (o_valid && i_ready && o_clamped && (o_clamp_cnt != '1)) begin
      o_clamp_cnt <= o_clamp_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_order_intensity_calc.sv
// Directed bench for order_intensity_calc with a scoreboard queue and an
// exp LUT stand-in of lut(x) = 1 + x/2.
module tb_order_intensity_calc;
  import hft_fixed_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic             o_ready;
  q32_32_t          i_delta;
  logic             cfg_we;
  q32_32_t          i_k;
  q32_32_t          i_a;
  q32_32_t          o_exp_arg;
  q32_32_t          exp_value;
  logic             o_valid;
  logic             i_ready;
  q32_32_t          o_lambda;
  logic             o_clamped;
  logic [CNT_W-1:0] o_clamp_cnt;

  // clock / reset
  always #5 clk = ~clk;

  order_intensity_calc #(.CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_delta     (i_delta),
    .i_cfg_we    (cfg_we),
    .i_k         (i_k),
    .i_a         (i_a),
    .o_exp_arg   (o_exp_arg),
    .i_exp_value (exp_value),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_lambda    (o_lambda),
    .o_clamped   (o_clamped),
    .o_clamp_cnt (o_clamp_cnt)
  );

  always_comb exp_value = Q_ONE + (o_exp_arg >>> 1);

  // scoreboard
  logic [64:0]      exp_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             prev_stall = 1'b0;
  q32_32_t          held_lam;
  q32_32_t          held_arg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  always begin
    logic [64:0] e;
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 1'b0;
      exp_cnt    = '0;
    end else begin
      if (prev_stall) begin
        check("stall_lambda", o_lambda, held_lam);
        check("stall_exp_arg", o_exp_arg, held_arg);
      end
      prev_stall = o_valid && !i_ready;
      held_lam   = o_lambda;
      held_arg   = o_exp_arg;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got lambda %h, required no output", o_lambda);
        end else begin
          e = exp_q.pop_front();
          check("lambda", o_lambda, e[63:0]);
          check("clamped", 64'(o_clamped), 64'(e[64]));
          if (e[64] && exp_cnt != '1) exp_cnt = exp_cnt + CNT_W'(1);
        end
      end
    end
  end

  // driver tasks; all start and end at negedge + 1
  task automatic cfg_write(input q32_32_t nk, input q32_32_t na);
    cfg_we = 1'b1;
    i_k    = nk;
    i_a    = na;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input q32_32_t d, input q32_32_t e_arg, input q32_32_t e_lam,
                      input logic e_cl, input logic with_cfg, input q32_32_t nk,
                      input q32_32_t na);
    int w = 0;
    i_valid = 1'b1;
    i_delta = d;
    if (with_cfg) begin
      cfg_we = 1'b1;
      i_k    = nk;
      i_a    = na;
    end
    while (!o_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!o_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got o_ready 0, required 1 within 50 cycles");
      i_valid = 1'b0;
      cfg_we  = 1'b0;
      return;
    end
    exp_q.push_back({e_cl, e_lam});
    @(posedge clk);
    #1 cfg_we = 1'b0;
    @(negedge clk);
    #1;
    i_valid = 1'b0;
    check("exp_arg", o_exp_arg, e_arg);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
    @(negedge clk);
    #1;
  endtask

  // backpressure stream, k = 1.0, A = 2.0: lambda = 2 + clamp(-delta)
  q32_32_t bp_d[8]   = '{64'sh0, 64'sh0000_0000_8000_0000, 64'sh0000_0000_4000_0000,
                         64'shFFFF_FFFF_8000_0000, 64'sh0000_0001_0000_0000,
                         64'shFFFF_FFFF_0000_0000, 64'sh0000_0002_0000_0000,
                         64'sh0000_0000_C000_0000};
  q32_32_t bp_arg[8] = '{64'sh0, 64'shFFFF_FFFF_8000_0000, 64'shFFFF_FFFF_C000_0000,
                         64'sh0000_0000_8000_0000, 64'shFFFF_FFFF_0000_0000,
                         64'sh0000_0001_0000_0000, 64'shFFFF_FFFF_0000_0000,
                         64'shFFFF_FFFF_4000_0000};
  q32_32_t bp_lam[8] = '{64'sh0000_0002_0000_0000, 64'sh0000_0001_8000_0000,
                         64'sh0000_0001_C000_0000, 64'sh0000_0002_8000_0000,
                         64'sh0000_0001_0000_0000, 64'sh0000_0003_0000_0000,
                         64'sh0000_0001_0000_0000, 64'sh0000_0001_4000_0000};
  logic    bp_cl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  localparam q32_32_t Q_TWO  = 64'sh0000_0002_0000_0000;
  localparam q32_32_t Q_HALF = 64'sh0000_0000_8000_0000;

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_delta = '0;
    cfg_we  = 1'b0;
    i_k     = '0;
    i_a     = '0;
    i_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_ready", 64'(o_ready), 64'd1);
    check("rst_o_lambda", o_lambda, 64'd0);
    check("rst_o_exp_arg", o_exp_arg, 64'd0);
    check("rst_o_clamped", 64'(o_clamped), 64'd0);
    check("rst_o_clamp_cnt", 64'(o_clamp_cnt), 64'd0);

    // zero distance, A at its reset value
    cfg_write(Q_ONE, Q_ONE);
    send(64'sh0, 64'sh0, Q_ONE, 1'b0, 1'b0, '0, '0);
    drain();

    // in-range: 2 * lut(-0.5) = 1.5
    cfg_write(Q_ONE, Q_TWO);
    send(Q_HALF, 64'shFFFF_FFFF_8000_0000, 64'sh0000_0001_8000_0000, 1'b0, 1'b0, '0, '0);

    // clamping both ways
    send(64'sh0000_0003_0000_0000, Q_NEG_ONE, Q_ONE, 1'b1, 1'b0, '0, '0);
    send(64'shFFFF_FFFD_0000_0000, Q_ONE, 64'sh0000_0003_0000_0000, 1'b1, 1'b0, '0, '0);
    drain();
    check("clamp_cnt_two", 64'(o_clamp_cnt), 64'd2);

    // back-to-back stream with a 4-cycle stall in the middle
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_d[i], bp_arg[i], bp_lam[i], bp_cl[i], 1'b0, '0, '0);
      end
      begin
        repeat (4) @(negedge clk);
        i_ready = 1'b0;
        repeat (4) @(negedge clk);
        i_ready = 1'b1;
      end
    join
    drain();

    // config write racing an accept: old k for this sample, new k after
    send(64'sh0000_0000_4000_0000, 64'shFFFF_FFFF_C000_0000, 64'sh0000_0001_C000_0000,
         1'b0, 1'b1, Q_TWO, Q_TWO);
    send(64'sh0000_0000_4000_0000, 64'shFFFF_FFFF_8000_0000, 64'sh0000_0001_8000_0000,
         1'b0, 1'b0, '0, '0);
    drain();

    // output saturation both ways
    cfg_write(Q_ONE, Q_MAX);
    send(Q_NEG_ONE, Q_ONE, Q_MAX, 1'b0, 1'b0, '0, '0);
    cfg_write(Q_ONE, Q_MIN);
    send(Q_NEG_ONE, Q_ONE, Q_MIN, 1'b0, 1'b0, '0, '0);
    drain();

    // argument saturation, including -(MIN * MIN)
    cfg_write(64'sh7FFF_FFFF_0000_0000, Q_ONE);
    send(64'sh0000_1000_0000_0000, Q_NEG_ONE, Q_HALF, 1'b1, 1'b0, '0, '0);
    cfg_write(Q_MIN, Q_ONE);
    send(Q_MIN, Q_NEG_ONE, Q_HALF, 1'b1, 1'b0, '0, '0);
    drain();
    check("clamp_cnt_total", 64'(o_clamp_cnt), 64'd5);
    check("clamp_cnt_model", 64'(o_clamp_cnt), 64'(exp_cnt));

    // reset with three samples in flight
    cfg_write(Q_ONE, Q_TWO);
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_delta = Q_HALF;
      @(negedge clk);
      #1;
    end
    i_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    #1;
    rst     = 1'b0;
    i_ready = 1'b1;
    check("post_rst_o_ready", 64'(o_ready), 64'd1);
    check("post_rst_clamp_cnt", 64'(o_clamp_cnt), 64'd0);
    check("post_rst_exp_arg", o_exp_arg, 64'd0);
    for (int i = 0; i < 6; i++) begin
      check("post_rst_o_valid", 64'(o_valid), 64'd0);
      @(negedge clk);
      #1;
    end
    // k = 0 and A = 1.0 after reset
    send(Q_HALF, 64'sh0, Q_ONE, 1'b0, 1'b0, '0, '0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/order_intensity_calc.md
# order_intensity_calc

Pipelined front-end to `exp_lut`. It computes the order-arrival intensity λ = A·exp(−k·δ) for a stream of quote distances δ, all in q32.32. It forms and clamps the exponent argument, drives the LUT index input, captures the looked-up value, and scales it by A. It sits between the quoting engine, which issues δ samples, and the spread/skew logic, which consumes λ through a valid/ready handshake.

## Interface
- `CNT_W`, default 16: width of the saturating clamp counter.
- `i_clk` in 1: clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_valid` in 1: δ sample valid.
- `o_ready` out 1: block accepts a sample this cycle.
- `i_delta` in 64: δ, signed q32.32.
- `i_cfg_we` in 1: load `i_k` and `i_a` into the config registers.
- `i_k` in 64: decay k, signed q32.32.
- `i_a` in 64: amplitude A, signed q32.32.
- `o_exp_arg` out 64: argument to `exp_lut.input_value`, signed q32.32.
- `i_exp_value` in 64: `exp_lut.exp_value`, combinational return of `o_exp_arg`.
- `o_valid` out 1: λ valid.
- `i_ready` in 1: downstream accepts λ.
- `o_lambda` out 64: λ, signed q32.32.
- `o_clamped` out 1: the argument for this λ was clamped.
- `o_clamp_cnt` out CNT_W: saturating count of clamped samples.

## Operation
- Config registers `k_r` and `a_r` reset to 0 and 64'h0000_0001_0000_0000 (1.0). They load on `i_cfg_we`. A sample accepted in the same cycle as a write uses the old values.
- Pipeline enable: `en = !(o_valid && !i_ready)`. `o_ready = en`. Every stage advances only when `en` is high.
- **S1, on accept.** Compute `arg = sat64((−k_r · i_delta) >>> 32)` using the full 128-bit signed product, bits [95:32]. Overflow saturates to 64'h7FFF_FFFF_FFFF_FFFF or 64'h8000_0000_0000_0000.
  - Clamp to [−1.0, +1.0], i.e. 64'hFFFF_FFFF_0000_0000 .. 64'h0000_0001_0000_0000.
  - Register the clamped arg, the clamp flag, `a_r` (snapshot) and the valid bit.
- `o_exp_arg` is driven directly from the S1 arg register. It holds while stalled.
- **S2.** Capture `i_exp_value` (treated as signed, always positive), the A snapshot, the flag and the valid bit.
- **S3.** Compute `o_lambda = sat64((A · exp) >>> 32)` with the same product and saturation rules. Register λ, `o_clamped` and `o_valid`.
- `o_clamp_cnt` increments when an S3 result with the flag set is handed over (`o_valid && i_ready && o_clamped`). It saturates at all-ones.
- Bubbles are carried as cleared valid bits. Stages with valid=0 still advance on `en`.

## Timing
- Reset values: `o_valid` 0, all stage valid bits 0, `o_lambda` 0, `o_exp_arg` 0, `o_clamped` 0, `o_clamp_cnt` 0, `o_ready` 1.
- Latency: a sample accepted at the clock edge ending cycle N gives `o_valid` = 1 in cycle N+3, assuming no stall.
- Throughput: one sample per cycle while `i_ready` is held high.
- Stall: while `o_valid && !i_ready`, all registers hold (including `o_exp_arg`), `o_ready` = 0, and `o_lambda` stays stable.
- Simultaneous accept and output handshake with `i_ready` = 1 is a normal full-throughput advance.
- `i_valid` while `o_ready` = 0: the sample is not taken. The upstream block must hold it.
- Reset mid-flight clears all in-flight samples and the config registers. No `o_valid` pulse follows. The cycle after reset deasserts, `o_ready` = 1.
- `i_exp_value` must be settled within the same cycle as `o_exp_arg`. The LUT is a combinational read.

## Structure
- Package `hft_fixed_pkg`:
  - `typedef logic signed [63:0] q32_32_t`
  - constants `Q_ONE` = 64'h0000_0001_0000_0000, `Q_NEG_ONE` = 64'hFFFF_FFFF_0000_0000, `Q_MAX`, `Q_MIN`
- Sub-module `q32_mul_sat`: combinational signed q32.32 multiply with 64-bit saturation. It is instantiated twice (S1 and S3).
- `exp_lut` is instantiated at the parent level, not inside this block.

## Test plan
- **Zero distance.** Reset, then k=1.0, δ=0. Required: `o_exp_arg`=0 in the cycle after accept; `o_lambda` = 1.0·LUT(0) in cycle N+3; `o_clamped`=0.
- **In-range argument.** k=1.0, A=2.0, δ=0.5 (64'h0000_0000_8000_0000). Required: `o_exp_arg`=64'hFFFF_FFFF_8000_0000; `o_lambda` = 2·LUT(−0.5), per the bench model.
- **Clamping.** δ=3.0 with k=1.0, then δ=−3.0. Required: args 64'hFFFF_FFFF_0000_0000 and 64'h0000_0001_0000_0000; `o_clamped`=1 on both; `o_clamp_cnt`=2 after both handshakes.
- **Backpressure.** A back-to-back stream of 8 samples, with `i_ready` low for 4 cycles mid-stream. Required: no loss or duplication; `o_lambda` and `o_exp_arg` stable while stalled; in-order output.
- **Config race.** `i_cfg_we` with k=2.0 in the same cycle as accepting δ=0.25 under k=1.0. Required: arg=−0.25. The next sample uses k=2.0.
- **Reset mid-flight.** Assert `i_reset` with 3 samples in flight. Required: no `o_valid` afterwards; `o_clamp_cnt`=0; A=1.0; k=0.
